// File: rtl/rob_retire_buffer_if.sv
// Dispatch, completion, retire and flush bundle between the core pipeline and the reorder buffer.
// The core side uses the master modport; the ROB uses the slave modport.
interface rob_retire_buffer_if #(
  parameter int unsigned NUM_ROB_ENTS = 64,
  parameter int unsigned RETIRE_WIDTH = 4,
  parameter int unsigned NUM_FUS      = 4,
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned NUM_PREGS    = 128
);
  localparam int unsigned IDX_W  = $clog2(NUM_ROB_ENTS);
  localparam int unsigned AREG_W = $clog2(NUM_AREGS);
  localparam int unsigned PREG_W = $clog2(NUM_PREGS);
  localparam int unsigned PC_W   = 32;

  logic                             disp_valid;
  logic                             disp_ready;
  logic [AREG_W-1:0]                disp_dst_areg;
  logic [PREG_W-1:0]                disp_dst_preg;
  logic [PC_W-1:0]                  disp_pc;
  logic [IDX_W-1:0]                 disp_rob_index;

  logic [NUM_FUS-1:0]               cmpl_valid;
  logic [NUM_FUS*IDX_W-1:0]         cmpl_rob_index;
  logic [NUM_FUS-1:0]               cmpl_exception;
  logic [NUM_FUS-1:0]               cmpl_br_mispred;

  logic [RETIRE_WIDTH-1:0]          ret_valid;
  logic [RETIRE_WIDTH*AREG_W-1:0]   ret_dst_areg;
  logic [RETIRE_WIDTH*PREG_W-1:0]   ret_dst_preg;
  logic [RETIRE_WIDTH*PC_W-1:0]     ret_pc;

  logic                             flush;
  logic [PC_W-1:0]                  flush_pc;
  logic                             flush_cause;

  modport master (
    output disp_valid, disp_dst_areg, disp_dst_preg, disp_pc,
    output cmpl_valid, cmpl_rob_index, cmpl_exception, cmpl_br_mispred,
    input  disp_ready, disp_rob_index,
    input  ret_valid, ret_dst_areg, ret_dst_preg, ret_pc,
    input  flush, flush_pc, flush_cause
  );

  modport slave (
    input  disp_valid, disp_dst_areg, disp_dst_preg, disp_pc,
    input  cmpl_valid, cmpl_rob_index, cmpl_exception, cmpl_br_mispred,
    output disp_ready, disp_rob_index,
    output ret_valid, ret_dst_areg, ret_dst_preg, ret_pc,
    output flush, flush_pc, flush_cause
  );
endinterface

// File: rtl/rob_retire_buffer.sv
// In-order reorder buffer: allocates at the tail, marks completions by index,
// retires up to RETIRE_WIDTH done entries from the head and flushes on mispredict/exception.
module rob_retire_buffer #(
  parameter int unsigned NUM_ROB_ENTS = 64,
  parameter int unsigned RETIRE_WIDTH = 4,
  parameter int unsigned NUM_FUS      = 4,
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned NUM_PREGS    = 128
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  rob_retire_buffer_if.slave                     bus,
  output logic [$clog2(NUM_ROB_ENTS+1)-1:0]      count_o,
  output logic                                   empty_o
);
  localparam int unsigned IDX_W  = $clog2(NUM_ROB_ENTS);
  localparam int unsigned CNT_W  = $clog2(NUM_ROB_ENTS+1);
  localparam int unsigned AREG_W = $clog2(NUM_AREGS);
  localparam int unsigned PREG_W = $clog2(NUM_PREGS);
  localparam int unsigned PC_W   = 32;

  logic [IDX_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM_ROB_ENTS-1:0] valid_q, valid_d, done_q, done_d;
  logic [NUM_ROB_ENTS-1:0] exc_q, exc_d, mis_q, mis_d;

  logic [AREG_W-1:0]       areg_q [NUM_ROB_ENTS];
  logic [PREG_W-1:0]       preg_q [NUM_ROB_ENTS];
  logic [PC_W-1:0]         pc_q   [NUM_ROB_ENTS];

  logic [IDX_W-1:0]        slot_idx [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] ret_valid_c;
  logic [CNT_W-1:0]        ret_cnt_c;
  logic                    ret_stop_c;
  logic                    flush_c, flush_cause_c;
  logic [PC_W-1:0]         flush_pc_c;
  logic                    disp_hs_c;
  logic [IDX_W-1:0]        cidx_c;
  logic                    dup_cmpl_c;

  // Retire window: only registered state feeds these outputs.
  always_comb begin
    ret_valid_c   = '0;
    ret_cnt_c     = '0;
    ret_stop_c    = 1'b0;
    flush_c       = 1'b0;
    flush_cause_c = 1'b0;
    flush_pc_c    = '0;
    for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
      slot_idx[k] = head_q + IDX_W'(k);
      if (!ret_stop_c) begin
        if (!(valid_q[slot_idx[k]] && done_q[slot_idx[k]])) begin
          ret_stop_c = 1'b1;
        end else if (exc_q[slot_idx[k]]) begin
          flush_c       = 1'b1;
          flush_cause_c = 1'b1;
          flush_pc_c    = pc_q[slot_idx[k]];
          ret_stop_c    = 1'b1;
        end else begin
          ret_valid_c[k] = 1'b1;
          ret_cnt_c      = ret_cnt_c + CNT_W'(1);
          if (mis_q[slot_idx[k]]) begin
            flush_c    = 1'b1;
            flush_pc_c = pc_q[slot_idx[k]];
            ret_stop_c = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
      bus.ret_dst_areg[k*AREG_W +: AREG_W] = areg_q[slot_idx[k]];
      bus.ret_dst_preg[k*PREG_W +: PREG_W] = preg_q[slot_idx[k]];
      bus.ret_pc[k*PC_W +: PC_W]           = pc_q[slot_idx[k]];
    end
  end

  assign bus.ret_valid      = ret_valid_c;
  assign bus.flush          = flush_c;
  assign bus.flush_pc       = flush_pc_c;
  assign bus.flush_cause    = flush_cause_c;
  assign bus.disp_ready     = (count_q < CNT_W'(NUM_ROB_ENTS)) && !flush_c;
  assign bus.disp_rob_index = tail_q;
  assign disp_hs_c          = bus.disp_valid && bus.disp_ready;
  assign count_o            = count_q;
  assign empty_o            = (count_q == '0);

  // Next state: completions first so a same-cycle retire clear wins; a flush discards everything.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    mis_d   = mis_q;
    head_d  = head_q + IDX_W'(ret_cnt_c);
    tail_d  = tail_q;
    count_d = count_q;
    cidx_c  = '0;
    for (int i = 0; i < int'(NUM_FUS); i++) begin
      cidx_c = bus.cmpl_rob_index[i*IDX_W +: IDX_W];
      if (bus.cmpl_valid[i] && valid_q[cidx_c]) begin
        done_d[cidx_c] = 1'b1;
        exc_d[cidx_c]  = exc_q[cidx_c] | bus.cmpl_exception[i];
        mis_d[cidx_c]  = mis_q[cidx_c] | bus.cmpl_br_mispred[i];
      end
    end
    for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
      if (ret_valid_c[k]) begin
        valid_d[slot_idx[k]] = 1'b0;
        done_d[slot_idx[k]]  = 1'b0;
        exc_d[slot_idx[k]]   = 1'b0;
        mis_d[slot_idx[k]]   = 1'b0;
      end
    end
    if (flush_c) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      mis_d   = '0;
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (disp_hs_c) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        exc_d[tail_q]   = 1'b0;
        mis_d[tail_q]   = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      count_d = count_q + CNT_W'(disp_hs_c) - ret_cnt_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      mis_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      mis_q   <= mis_d;
    end
  end

  // Payload is write-only on allocation and needs no reset.
  always_ff @(posedge clk) begin
    if (disp_hs_c) begin
      areg_q[tail_q] <= bus.disp_dst_areg;
      preg_q[tail_q] <= bus.disp_dst_preg;
      pc_q[tail_q]   <= bus.disp_pc;
    end
  end

  always_comb begin
    dup_cmpl_c = 1'b0;
    for (int i = 0; i < int'(NUM_FUS); i++) begin
      for (int j = i + 1; j < int'(NUM_FUS); j++) begin
        if (bus.cmpl_valid[i] && bus.cmpl_valid[j] &&
            bus.cmpl_rob_index[i*IDX_W +: IDX_W] == bus.cmpl_rob_index[j*IDX_W +: IDX_W]) begin
          dup_cmpl_c = 1'b1;
        end
      end
    end
  end

  a_no_dup_cmpl: assert property (@(posedge clk) disable iff (!rst_n) !dup_cmpl_c);

endmodule

// File: tb/tb_rob_retire_buffer.sv
// Random dispatch/completion traffic against a queue-based model of the reorder buffer.
module tb_rob_retire_buffer;
  localparam int unsigned N  = 64;
  localparam int unsigned RW = 4;
  localparam int unsigned NF = 4;
  localparam int unsigned IW = 6;

  typedef struct {
    logic [4:0]  areg;
    logic [6:0]  preg;
    logic [31:0] pc;
    bit          done;
    bit          exc;
    bit          mis;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] count_o;
  logic       empty_o;

  rob_retire_buffer_if bus ();

  rob_retire_buffer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count_o (count_o),
    .empty_o (empty_o)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  ent_t rob[$];
  int   head  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.disp_valid      = 1'b0;
    bus.disp_dst_areg   = '0;
    bus.disp_dst_preg   = '0;
    bus.disp_pc         = '0;
    bus.cmpl_valid      = '0;
    bus.cmpl_rob_index  = '0;
    bus.cmpl_exception  = '0;
    bus.cmpl_br_mispred = '0;
  endtask

  // One cycle: drive random inputs, check outputs against the model, advance the model.
  task automatic step(input int p_disp, input int p_cmpl, input int p_flag);
    logic [NF-1:0]    cv, ce, cm;
    logic [NF*IW-1:0] ci;
    bit               used [N];
    logic [RW-1:0]    ev;
    int               ev_n, sz, r;
    bit               ef, ecause, stop, exp_ready, hs;
    logic [31:0]      epc;
    ent_t             e;
    @(negedge clk);
    cv = '0; ce = '0; cm = '0; ci = '0;
    foreach (used[j]) used[j] = 1'b0;
    sz = rob.size();
    for (int i = 0; i < int'(NF); i++) begin
      int idx, pos;
      if ($urandom_range(99) >= p_cmpl) continue;
      if (sz == 0 || $urandom_range(9) == 0) begin
        idx = int'($urandom_range(N-1));
      end else begin
        pos = int'($urandom_range(sz-1));
        if (rob[pos].done) continue;
        idx = (head + pos) % int'(N);
      end
      if (used[idx]) continue;
      used[idx] = 1'b1;
      cv[i] = 1'b1;
      ci[i*IW +: IW] = IW'(idx);
      r = int'($urandom_range(99));
      if (r < p_flag) ce[i] = 1'b1;
      else if (r < 2*p_flag) cm[i] = 1'b1;
    end
    bus.disp_valid      = ($urandom_range(99) < p_disp);
    bus.disp_dst_areg   = 5'($urandom);
    bus.disp_dst_preg   = 7'($urandom);
    bus.disp_pc         = $urandom;
    bus.cmpl_valid      = cv;
    bus.cmpl_rob_index  = ci;
    bus.cmpl_exception  = ce;
    bus.cmpl_br_mispred = cm;
    #1;
    ev = '0; ev_n = 0; ef = 1'b0; ecause = 1'b0; epc = '0; stop = 1'b0;
    for (int k = 0; k < int'(RW) && k < sz && !stop; k++) begin
      if (!rob[k].done) begin
        stop = 1'b1;
      end else if (rob[k].exc) begin
        ef = 1'b1; ecause = 1'b1; epc = rob[k].pc; stop = 1'b1;
      end else begin
        ev[k] = 1'b1; ev_n++;
        if (rob[k].mis) begin ef = 1'b1; epc = rob[k].pc; stop = 1'b1; end
      end
    end
    exp_ready = (sz < int'(N)) && !ef;
    check_eq("ret_valid", 64'(bus.ret_valid), 64'(ev));
    check_eq("flush", 64'(bus.flush), 64'(ef));
    if (ef) begin
      check_eq("flush_pc", 64'(bus.flush_pc), 64'(epc));
      check_eq("flush_cause", 64'(bus.flush_cause), 64'(ecause));
    end
    for (int k = 0; k < ev_n; k++) begin
      check_eq($sformatf("ret_pc[%0d]", k), 64'(bus.ret_pc[k*32 +: 32]), 64'(rob[k].pc));
      check_eq($sformatf("ret_areg[%0d]", k), 64'(bus.ret_dst_areg[k*5 +: 5]), 64'(rob[k].areg));
      check_eq($sformatf("ret_preg[%0d]", k), 64'(bus.ret_dst_preg[k*7 +: 7]), 64'(rob[k].preg));
    end
    check_eq("disp_ready", 64'(bus.disp_ready), 64'(exp_ready));
    check_eq("disp_rob_index", 64'(bus.disp_rob_index), 64'((head + sz) % int'(N)));
    check_eq("count", 64'(count_o), 64'(sz));
    check_eq("empty", 64'(empty_o), 64'(sz == 0));

    hs = bus.disp_valid && exp_ready;
    if (!ef) begin
      for (int i = 0; i < int'(NF); i++) begin
        int pos;
        if (!cv[i]) continue;
        pos = (int'(ci[i*IW +: IW]) - head + int'(N)) % int'(N);
        if (pos < sz) begin
          e = rob[pos];
          e.done = 1'b1;
          e.exc  = e.exc | ce[i];
          e.mis  = e.mis | cm[i];
          rob[pos] = e;
        end
      end
    end
    for (int k = 0; k < ev_n; k++) begin
      void'(rob.pop_front());
      head = (head + 1) % int'(N);
    end
    if (ef) begin
      rob.delete();
    end else if (hs) begin
      e.areg = bus.disp_dst_areg;
      e.preg = bus.disp_dst_preg;
      e.pc   = bus.disp_pc;
      e.done = 1'b0; e.exc = 1'b0; e.mis = 1'b0;
      rob.push_back(e);
    end
  endtask

  task automatic check_reset_state(input string phase);
    check_eq({phase, "_count"}, 64'(count_o), 64'd0);
    check_eq({phase, "_empty"}, 64'(empty_o), 64'd1);
    check_eq({phase, "_ret_valid"}, 64'(bus.ret_valid), 64'd0);
    check_eq({phase, "_flush"}, 64'(bus.flush), 64'd0);
    check_eq({phase, "_disp_ready"}, 64'(bus.disp_ready), 64'd1);
    check_eq({phase, "_disp_rob_index"}, 64'(bus.disp_rob_index), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #12;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 1500; c++) step(70, 60, 3);
    for (int c = 0; c < 800;  c++) step(95, 6, 2);
    for (int c = 0; c < 1000; c++) step(60, 70, 12);
    for (int c = 0; c < 300;  c++) step(95, 6, 2);

    // Asynchronous reset mid-operation, checked before any clock edge.
    @(negedge clk);
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rob.delete();
    head = 0;

    for (int c = 0; c < 600; c++) step(75, 55, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
